// File: rtl/mcdf_arb_n.sv
// NCH-channel MCDF arbiter: per-channel FIFOs merged into one packet stream,
// strict priority with round-robin among equal priorities.
module mcdf_arb_n #(
    parameter  int NCH   = 4,
    parameter  int DW    = 32,
    parameter  int DEPTH = 32,
    localparam int ID_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NCH*DW-1:0]   ch_data_i,
    input  logic [NCH-1:0]      ch_valid_i,
    output logic [NCH-1:0]      ch_ready_o,
    input  logic [NCH-1:0]      cfg_en_i,
    input  logic [NCH*2-1:0]    cfg_prio_i,
    input  logic [NCH*3-1:0]    cfg_pkglen_i,
    output logic [NCH*8-1:0]    margin_o,
    input  logic                f2a_id_req_i,
    input  logic                f2a_ack_i,
    output logic                a2f_val_o,
    output logic [ID_W-1:0]     a2f_id_o,
    output logic [DW-1:0]       a2f_data_o,
    output logic [2:0]          a2f_pkglen_sel_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem    [NCH][DEPTH];
    logic [AW-1:0]   wr_ptr [NCH];
    logic [AW-1:0]   rd_ptr [NCH];
    logic [CW-1:0]   count  [NCH];
    logic [NCH-1:0]  rdy, push, pop, elig;
    logic [ID_W-1:0] rr_ptr, winner;
    logic            win_found, grant_go, xfer_pop;
    logic [1:0]      best_prio;
    int unsigned     idx;
    logic [5:0]      pkt_len, wcnt;

    function automatic logic [5:0] len_decode(input logic [2:0] sel);
        case (sel)
            3'd0:    len_decode = 6'd4;
            3'd1:    len_decode = 6'd8;
            3'd2:    len_decode = 6'd16;
            default: len_decode = 6'd32;
        endcase
    endfunction

    assign a2f_val_o  = (state == S_XFER) && (count[a2f_id_o] != '0);
    assign a2f_data_o = (state == S_XFER) ? mem[a2f_id_o][rd_ptr[a2f_id_o]] : '0;
    assign xfer_pop   = a2f_val_o && f2a_ack_i;
    assign ch_ready_o = rdy;

    always_comb begin
        rdy      = '0;
        push     = '0;
        pop      = '0;
        elig     = '0;
        margin_o = '0;
        for (int unsigned n = 0; n < NCH; n++) begin
            rdy[n]             = cfg_en_i[n] && (count[n] < CW'(DEPTH));
            push[n]            = ch_valid_i[n] && rdy[n];
            pop[n]             = xfer_pop && (a2f_id_o == ID_W'(n));
            elig[n]            = cfg_en_i[n] && (count[n] != '0);
            margin_o[n*8 +: 8] = 8'(CW'(DEPTH) - count[n]);
        end
    end

    // Scan cyclically from rr_ptr+1; strict '<' keeps the first tied channel.
    always_comb begin
        win_found = 1'b0;
        winner    = rr_ptr;
        best_prio = 2'd3;
        idx       = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(rr_ptr) + k) % NCH;
            if (elig[idx] && (!win_found || cfg_prio_i[idx*2 +: 2] < best_prio)) begin
                win_found = 1'b1;
                winner    = ID_W'(idx);
                best_prio = cfg_prio_i[idx*2 +: 2];
            end
        end
    end

    assign grant_go = (state == S_IDLE) && f2a_id_req_i && win_found;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (grant_go) state_nx = S_XFER;
            S_XFER: if (xfer_pop && (wcnt == pkt_len - 6'd1)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= S_IDLE;
            a2f_id_o         <= '0;
            a2f_pkglen_sel_o <= '0;
            rr_ptr           <= ID_W'(NCH - 1);
            pkt_len          <= '0;
            wcnt             <= '0;
        end else begin
            state <= state_nx;
            if (grant_go) begin
                a2f_id_o         <= winner;
                rr_ptr           <= winner;
                a2f_pkglen_sel_o <= cfg_pkglen_i[32'(winner)*3 +: 3];
                pkt_len          <= len_decode(cfg_pkglen_i[32'(winner)*3 +: 3]);
                wcnt             <= '0;
            end else if (xfer_pop) begin
                wcnt <= wcnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned n = 0; n < NCH; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < NCH; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + AW'(1);
                if (push[n] && !pop[n])      count[n] <= count[n] + CW'(1);
                else if (pop[n] && !push[n]) count[n] <= count[n] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned n = 0; n < NCH; n++) begin
            if (push[n]) mem[n][wr_ptr[n]] <= ch_data_i[n*DW +: DW];
        end
    end
endmodule

// File: tb/tb_mcdf_arb_n.sv
// Directed self-checking bench for mcdf_arb_n (NCH=4, DW=32, DEPTH=32).
module tb_mcdf_arb_n;
    logic         clk = 1'b0;
    logic         rstn;
    logic [127:0] ch_data;
    logic [3:0]   ch_valid, ch_ready, cfg_en;
    logic [7:0]   cfg_prio;
    logic [11:0]  cfg_pkglen;
    logic [31:0]  margin;
    logic         req, ack, val;
    logic [1:0]   id;
    logic [31:0]  data;
    logic [2:0]   sel;

    int checks   = 0;
    int failures = 0;

    mcdf_arb_n #(.NCH(4), .DW(32), .DEPTH(32)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .ch_data_i        (ch_data),
        .ch_valid_i       (ch_valid),
        .ch_ready_o       (ch_ready),
        .cfg_en_i         (cfg_en),
        .cfg_prio_i       (cfg_prio),
        .cfg_pkglen_i     (cfg_pkglen),
        .margin_o         (margin),
        .f2a_id_req_i     (req),
        .f2a_ack_i        (ack),
        .a2f_val_o        (val),
        .a2f_id_o         (id),
        .a2f_data_o       (data),
        .a2f_pkglen_sel_o (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            ch_valid[ch]          = 1'b1;
            ch_data[ch*32 +: 32]  = first + 32'(i);
            @(negedge clk);
        end
        ch_valid[ch] = 1'b0;
    endtask

    task automatic recv_words(input logic [1:0] exp_id, input int n, input logic [31:0] first);
        int t;
        ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (val !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("word_valid", 32'(val), 32'd1);
            chk("word_data", data, first + 32'(i));
            chk("word_id", 32'(id), 32'(exp_id));
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic recv_pkt(input logic [1:0] exp_id, input logic [2:0] exp_sel,
                            input int n, input logic [31:0] first);
        int t;
        t = 0;
        while (val !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("grant_sel", 32'(sel), 32'(exp_sel));
        recv_words(exp_id, n, first);
    endtask

    initial begin
        int t;
        rstn = 1'b0; ch_data = '0; ch_valid = '0; cfg_en = 4'b0001;
        cfg_prio = '0; cfg_pkglen = '0; req = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_val", 32'(val), 32'd0);
        chk("rst_id", 32'(id), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_margin", margin, 32'h20202020);
        chk("rst_ready", 32'(ch_ready), 32'h1);

        // Basic transfer on ch0
        push(0, 32'hA0, 4);
        chk("basic_margin_fill", 32'(margin[7:0]), 32'd28);
        req = 1'b1;
        recv_pkt(2'd0, 3'd0, 4, 32'hA0);
        chk("basic_gap_val", 32'(val), 32'd0);
        chk("basic_margin_drain", 32'(margin[7:0]), 32'd32);

        // ch1 prio 0, ch0/ch2 prio 1. rr_ptr=0 after the ch0 packet; ch1 wins on
        // priority (rr->1), then the 0/2 tie resolves from rr+1: ch2, then ch0.
        req = 1'b0; cfg_en = 4'b0111; cfg_prio = 8'h11;
        push(1, 32'h100, 4);
        push(0, 32'h200, 8);
        push(2, 32'h300, 8);
        req = 1'b1;
        recv_pkt(2'd1, 3'd0, 4, 32'h100);
        recv_pkt(2'd2, 3'd0, 4, 32'h300);
        recv_pkt(2'd0, 3'd0, 4, 32'h200);
        req = 1'b0;
        push(1, 32'h110, 4);
        req = 1'b1;
        recv_pkt(2'd1, 3'd0, 4, 32'h110);
        recv_pkt(2'd2, 3'd0, 4, 32'h304);
        recv_pkt(2'd0, 3'd0, 4, 32'h204);

        // Equal priorities: rr=0 so ch1 wins, leaving rr=1 -> ch2 next, then ch0
        req = 1'b0; cfg_prio = 8'h00;
        push(1, 32'h120, 4);
        push(0, 32'h210, 4);
        push(2, 32'h310, 4);
        req = 1'b1;
        recv_pkt(2'd1, 3'd0, 4, 32'h120);
        recv_pkt(2'd2, 3'd0, 4, 32'h310);
        recv_pkt(2'd0, 3'd0, 4, 32'h210);

        // Full FIFO on ch3
        req = 1'b0; cfg_en = 4'b1000;
        push(3, 32'h400, 32);
        chk("full_ready", 32'(ch_ready[3]), 32'd0);
        chk("full_margin", 32'(margin[31:24]), 32'd0);
        ch_valid[3] = 1'b1; ch_data[127:96] = 32'hDEAD;
        @(negedge clk);
        ch_valid[3] = 1'b0;
        chk("full_no_take", 32'(margin[31:24]), 32'd0);
        req = 1'b1;
        t = 0;
        while (val !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("full_grant_val", 32'(val), 32'd1);
        chk("full_head", data, 32'h400);
        chk("full_ready_prepop", 32'(ch_ready[3]), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("full_ready_after_pop", 32'(ch_ready[3]), 32'd1);
        chk("full_margin_after_pop", 32'(margin[31:24]), 32'd1);
        recv_words(2'd3, 3, 32'h401);
        for (int p = 1; p < 8; p++) recv_pkt(2'd3, 3'd0, 4, 32'h400 + 32'(p * 4));
        chk("full_drained", 32'(margin[31:24]), 32'd32);

        // Mid-packet stall: 8-word packet with only 3 words stored
        req = 1'b0; cfg_en = 4'b0101; cfg_pkglen = 12'h001;
        push(0, 32'h500, 3);
        req = 1'b1;
        recv_pkt(2'd0, 3'd1, 3, 32'h500);
        chk("stall_val", 32'(val), 32'd0);
        push(2, 32'h600, 4);
        chk("stall_held_val", 32'(val), 32'd0);
        chk("stall_held_id", 32'(id), 32'd0);
        push(0, 32'h503, 5);
        recv_words(2'd0, 5, 32'h503);
        recv_pkt(2'd2, 3'd0, 4, 32'h600);

        // Disable mid-packet
        req = 1'b0; cfg_en = 4'b0001; cfg_pkglen = '0;
        push(0, 32'h700, 8);
        req = 1'b1;
        recv_pkt(2'd0, 3'd0, 2, 32'h700);
        cfg_en = 4'b0000;
        recv_words(2'd0, 2, 32'h702);
        chk("dis_ready", 32'(ch_ready[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("dis_no_grant", 32'(val), 32'd0);
        chk("dis_kept_words", 32'(margin[7:0]), 32'd28);

        // Reset during XFER
        cfg_en = 4'b0100;
        push(2, 32'h800, 4);
        recv_pkt(2'd2, 3'd0, 2, 32'h800);
        chk("rstx_pre_val", 32'(val), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rstx_val", 32'(val), 32'd0);
        chk("rstx_data", data, 32'd0);
        chk("rstx_id", 32'(id), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rstx_margin", margin, 32'h20202020);
        chk("rstx_ready", 32'(ch_ready), 32'h4);
        chk("rstx_idle_val", 32'(val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
